// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the single Sysbus master port between the instruction
// line-fill path and the data path (line reads and 512-bit write-backs).
// Requests are granted round-robin, one transaction at a time. Read response
// beats are assembled into a full line, and bus snoops are turned into
// invalidate pulses for the data side.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 i_req_valid,
    input  logic [BUS_DATA_WIDTH-1:0]            i_req_addr,
    output logic                                 i_req_ready,
    output logic                                 i_resp_valid,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] i_resp_data,

    input  logic                                 d_req_valid,
    input  logic                                 d_req_write,
    input  logic [BUS_DATA_WIDTH-1:0]            d_req_addr,
    input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] d_req_wdata,
    output logic                                 d_req_ready,
    output logic                                 d_resp_valid,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] d_resp_data,

    output logic                                 inv_valid,
    output logic [BUS_DATA_WIDTH-1:0]            inv_addr,

    output logic                                 bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]            bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    input  logic                                 bus_reqack,
    input  logic                                 bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
    output logic                                 bus_respack
);

    localparam int LINE_W = BUS_DATA_WIDTH * LINE_BEATS;
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    // Line-aligned address mask: clears the byte offset within a line.
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK =
        ~BUS_DATA_WIDTH'(LINE_W / 8 - 1);

    // Tag the bus uses for invalidation snoops.
    localparam logic [BUS_TAG_WIDTH-1:0] SNOOP_TAG = BUS_TAG_WIDTH'(13'h0800);

    // Requester identifiers, also used as the low tag bit.
    localparam logic ID_INSTR = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                state_q,     state_d;
    logic [BEAT_W-1:0]         beat_q,      beat_d;
    logic [LINE_W-1:0]         line_q,      line_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q,      addr_d;
    logic                      write_q,     write_d;
    logic [LINE_W-1:0]         wdata_q,     wdata_d;
    logic                      owner_q,     owner_d;
    logic                      lastGrant_q, lastGrant_d;
    logic                      invValid_q;
    logic [BUS_DATA_WIDTH-1:0] invAddr_q;

    logic                      grantInstr;
    logic                      grantData;
    logic                      snoopHit;
    logic                      beatHit;
    logic                      doneOut;
    logic [BUS_TAG_WIDTH-1:0]  ownTag;
    logic [BUS_TAG_WIDTH-1:0]  readTag;

    // Request tag: bit 12 set for reads, requester id in bit 0.
    assign ownTag   = BUS_TAG_WIDTH'({~write_q, 4'b0001, 7'b0, owner_q});
    assign readTag  = BUS_TAG_WIDTH'({1'b1,     4'b0001, 7'b0, owner_q});
    assign snoopHit = bus_respcyc && (bus_resptag == SNOOP_TAG);
    assign beatHit  = bus_respcyc && (bus_resptag == readTag);
    assign doneOut  = !reset && (state_q == S_DONE);

    // Next-state logic: arbitration, address phase, write beats, read assembly.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        grantInstr  = 1'b0;
        grantData   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!reset) begin
                    if (i_req_valid && (!d_req_valid || lastGrant_q == ID_DATA)) begin
                        grantInstr = 1'b1;
                    end else if (d_req_valid) begin
                        grantData = 1'b1;
                    end
                end
                if (grantInstr) begin
                    owner_d     = ID_INSTR;
                    addr_d      = i_req_addr;
                    write_d     = 1'b0;
                    wdata_d     = '0;
                    lastGrant_d = ID_INSTR;
                    line_d      = '0;
                    beat_d      = '0;
                    state_d     = S_ADDR;
                end else if (grantData) begin
                    owner_d     = ID_DATA;
                    addr_d      = d_req_addr;
                    write_d     = d_req_write;
                    wdata_d     = d_req_wdata;
                    lastGrant_d = ID_DATA;
                    line_d      = '0;
                    beat_d      = '0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_reqack) begin
                    beat_d  = '0;
                    state_d = write_q ? S_WR_DATA : S_RD_WAIT;
                end
            end
            S_WR_DATA: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_RD_WAIT: begin
                if (beatHit) begin
                    line_d[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                beat_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction state registers; reset discards any partially built line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            line_q      <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            owner_q     <= ID_INSTR;
            lastGrant_q <= ID_DATA;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Snoop capture: one-cycle invalidate pulse after each snoop beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            invValid_q <= 1'b0;
            invAddr_q  <= '0;
        end else begin
            invValid_q <= snoopHit;
            invAddr_q  <= snoopHit ? bus_resp : '0;
        end
    end

    // Bus request drive: address beat in ADDR, write-back beats in WR_DATA.
    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        if (!reset) begin
            if (state_q == S_ADDR) begin
                bus_reqcyc = 1'b1;
                bus_req    = write_q ? addr_q : (addr_q & LINE_MASK);
                bus_reqtag = ownTag;
            end else if (state_q == S_WR_DATA) begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                bus_reqtag = ownTag;
            end
        end
    end

    assign bus_respack  = bus_respcyc && !reset;

    assign i_req_ready  = grantInstr;
    assign d_req_ready  = grantData;

    assign i_resp_valid = doneOut && (owner_q == ID_INSTR);
    assign d_resp_valid = doneOut && (owner_q == ID_DATA);
    assign i_resp_data  = i_resp_valid ? line_q : '0;
    assign d_resp_data  = (d_resp_valid && !write_q) ? line_q : '0;

    assign inv_valid    = invValid_q && !reset;
    assign inv_addr     = reset ? '0 : invAddr_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Testbench for sysbus_arbiter: per-scenario tasks with a queue of expected
// line responses pushed when a request is issued and popped when a response
// pulse appears.
module tb_sysbus_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req_valid;
    logic [63:0]  i_req_addr;
    logic         i_req_ready;
    logic         i_resp_valid;
    logic [511:0] i_resp_data;
    logic         d_req_valid;
    logic         d_req_write;
    logic [63:0]  d_req_addr;
    logic [511:0] d_req_wdata;
    logic         d_req_ready;
    logic         d_resp_valid;
    logic [511:0] d_resp_data;
    logic         inv_valid;
    logic [63:0]  inv_addr;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;
    logic         bus_respack;

    typedef struct {
        bit           side;
        logic [511:0] data;
    } resp_t;

    resp_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    iCount = 0;
    int    dCount = 0;

    sysbus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_write  (d_req_write),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .inv_valid    (inv_valid),
        .inv_addr     (inv_addr),
        .bus_reqcyc   (bus_reqcyc),
        .bus_req      (bus_req),
        .bus_reqtag   (bus_reqtag),
        .bus_reqack   (bus_reqack),
        .bus_respcyc  (bus_respcyc),
        .bus_resp     (bus_resp),
        .bus_resptag  (bus_resptag),
        .bus_respack  (bus_respack)
    );

    always #5 clk = ~clk;

    // Count response pulses on both sides.
    always @(negedge clk) begin
        if (i_resp_valid) iCount++;
        if (d_resp_valid) dCount++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drive point: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] makeLine(input logic [63:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    // Wait (bounded) for a response pulse on either side.
    task automatic wait_resp(output bit got, output bit side, output logic [511:0] data);
        got  = 0;
        side = 0;
        data = '0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (i_resp_valid || d_resp_valid) begin
                got  = 1;
                side = d_resp_valid;
                data = d_resp_valid ? d_resp_data : i_resp_data;
                break;
            end
        end
    endtask

    // Drive eight matching read beats on consecutive cycles.
    task automatic serve_beats(input bit id, input logic [63:0] base, output bit ackOk);
        ackOk = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            bus_reqack  = 0;
            bus_respcyc = 1;
            bus_resptag = {1'b1, 4'b0001, 7'b0, id};
            bus_resp    = base + 64'(k);
            @(negedge clk);
            if (bus_respack !== 1'b1) ackOk = 0;
        end
        tick();
        bus_respcyc = 0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    task automatic test_reset();
        reset       = 1;
        i_req_valid = 1;
        i_req_addr  = 64'h40;
        d_req_valid = 1;
        d_req_write = 0;
        d_req_addr  = 64'h80;
        d_req_wdata = '0;
        bus_reqack  = 0;
        bus_respcyc = 1;
        bus_resp    = 64'h1234;
        bus_resptag = 13'h0800;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack} !== 7'b0)
            begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack}); end
        tick();
        reset       = 0;
        i_req_valid = 0;
        d_req_valid = 0;
        bus_respcyc = 0;
        bus_resp    = '0;
        bus_resptag = '0;
        @(negedge clk);
        checks++;
        if ({i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack} !== 7'b0)
            begin errors++; $display("[TB] FAIL idle_ctrl: got %b expected 0", {i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack}); end
        checks++;
        if ((|{i_resp_data, d_resp_data, inv_addr, bus_req, bus_reqtag}) !== 1'b0)
            begin errors++; $display("[TB] FAIL idle_data: some data output nonzero, expected all 0"); end
    endtask

    task automatic test_instr_read();
        int           d0;
        bit           got, side, ok;
        logic [511:0] data;
        resp_t        e;
        logic [511:0] expLine;
        d0 = dCount;
        tick();
        i_req_valid = 1;
        i_req_addr  = 64'h1_0047;
        @(negedge clk);
        checks++;
        if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL ir_grant: got i=%b d=%b expected i=1 d=0", i_req_ready, d_req_ready); end
        expLine = '0;
        for (int k = 0; k < 8; k++) expLine[64*k +: 64] = 64'((k + 1) * 17);
        expQ.push_back('{1'b0, expLine});
        for (int c = 0; c < 3; c++) begin
            tick();
            i_req_valid = 0;
            bus_reqack  = (c == 2);
            @(negedge clk);
            checks++;
            if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h1_0040, 13'h1100})
                begin errors++; $display("[TB] FAIL ir_addr%0d: got cyc=%b req=%h tag=%h expected 1 10040 1100", c, bus_reqcyc, bus_req, bus_reqtag); end
        end
        ok = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            bus_reqack  = 0;
            bus_respcyc = 1;
            bus_resptag = 13'h1100;
            bus_resp    = 64'((k + 1) * 17);
            @(negedge clk);
            if (bus_respack !== 1'b1 || bus_reqcyc !== 1'b0) ok = 0;
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL ir_beats: respack/reqcyc wrong during beats, expected 1/0"); end
        tick();
        bus_respcyc = 0;
        bus_resp    = '0;
        bus_resptag = '0;
        wait_resp(got, side, data);
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL ir_resp: got no response, expected i_resp_valid");
        end else begin
            e = expQ.pop_front();
            checks++;
            if (side !== e.side || data !== e.data)
                begin errors++; $display("[TB] FAIL ir_line: got side=%b data=%h expected side=%b data=%h", side, data, e.side, e.data); end
            checks++;
            if (data[63:0] !== 64'h11 || data[511:448] !== 64'h88)
                begin errors++; $display("[TB] FAIL ir_ends: got %h/%h expected 11/88", data[63:0], data[511:448]); end
        end
        @(negedge clk);
        checks++;
        if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL ir_pulse: got i=%b d=%b expected 0 0", i_resp_valid, d_resp_valid); end
        tick();
        checks++;
        if (dCount !== d0) begin errors++; $display("[TB] FAIL ir_dside: got %0d d pulses expected 0", dCount - d0); end
    endtask

    task automatic test_arbitration();
        bit           found, side, both, got, rside, ok;
        logic [511:0] data;
        resp_t        e;
        reset       = 1;
        i_req_valid = 1;
        d_req_valid = 1;
        d_req_write = 0;
        i_req_addr  = 64'h100;
        d_req_addr  = 64'h200;
        tick();
        tick();
        reset = 0;
        for (int n = 0; n < 4; n++) begin
            found = 0; side = 0; both = 0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (i_req_ready || d_req_ready) begin
                    found = 1;
                    side  = d_req_ready;
                    both  = i_req_ready && d_req_ready;
                    break;
                end
            end
            checks++;
            if (!found || both || side !== bit'(n % 2))
                begin errors++; $display("[TB] FAIL arb_order%0d: got found=%b side=%b both=%b expected side=%0d", n, found, side, both, n % 2); end
            expQ.push_back('{bit'(n % 2), makeLine(64'(n * 256 + 16))});
            tick();
            @(negedge clk);
            checks++;
            if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0 || bus_reqcyc !== 1'b1)
                begin errors++; $display("[TB] FAIL arb_pulse%0d: got i=%b d=%b cyc=%b expected 0 0 1", n, i_req_ready, d_req_ready, bus_reqcyc); end
            bus_reqack = 1;
            serve_beats(bit'(n % 2), 64'(n * 256 + 16), ok);
            wait_resp(got, rside, data);
            if (n == 3) begin
                i_req_valid = 0;
                d_req_valid = 0;
            end
            checks++;
            if (!got) begin
                errors++; $display("[TB] FAIL arb_resp%0d: got no response", n);
            end else begin
                e = expQ.pop_front();
                checks++;
                if (rside !== e.side || data !== e.data)
                    begin errors++; $display("[TB] FAIL arb_line%0d: got side=%b data=%h expected side=%b data=%h", n, rside, data, e.side, e.data); end
            end
        end
    endtask

    task automatic test_write_back(input logic [63:0] addr);
        bit           got, side;
        logic [511:0] data;
        resp_t        e;
        tick();
        d_req_valid = 1;
        d_req_write = 1;
        d_req_addr  = addr;
        for (int k = 0; k < 8; k++) d_req_wdata[64*k +: 64] = 64'(k + 1);
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL wb_grant: got d=%b i=%b expected 1 0", d_req_ready, i_req_ready); end
        expQ.push_back('{1'b1, 512'b0});
        tick();
        d_req_valid = 0;
        d_req_write = 0;
        bus_reqack  = 1;
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, addr, 13'h0101})
            begin errors++; $display("[TB] FAIL wb_addr: got cyc=%b req=%h tag=%h expected 1 %h 0101", bus_reqcyc, bus_req, bus_reqtag, addr); end
        for (int k = 0; k < 8; k++) begin
            tick();
            bus_reqack = 0;
            @(negedge clk);
            checks++;
            if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'(k + 1), 13'h0101})
                begin errors++; $display("[TB] FAIL wb_beat%0d: got cyc=%b req=%h tag=%h expected 1 %h 0101", k, bus_reqcyc, bus_req, bus_reqtag, k + 1); end
        end
        wait_resp(got, side, data);
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL wb_resp: got no response");
        end else begin
            e = expQ.pop_front();
            checks++;
            if (side !== e.side || data !== e.data || bus_reqcyc !== 1'b0)
                begin errors++; $display("[TB] FAIL wb_done: got side=%b data=%h cyc=%b expected side=1 data=0 cyc=0", side, data, bus_reqcyc); end
        end
    endtask

    task automatic test_snoop();
        logic [12:0]  tags[11];
        logic [63:0]  vals[11];
        bit           got, side, ok;
        logic [511:0] data;
        resp_t        e;
        for (int c = 0; c < 4; c++) begin tags[c] = 13'h1101; vals[c] = 64'hD000 + 64'(c); end
        tags[4] = 13'h0800; vals[4] = 64'h3000;
        tags[5] = 13'h1101; vals[5] = 64'hD004;
        tags[6] = 13'h1101; vals[6] = 64'hD005;
        tags[7] = 13'h1100; vals[7] = 64'hBAD0;
        tags[8] = 13'h1101; vals[8] = 64'hD006;
        tags[9] = 13'h1101; vals[9] = 64'hD007;
        tags[10] = 13'h1101; vals[10] = 64'hD007;
        tick();
        d_req_valid = 1;
        d_req_write = 0;
        d_req_addr  = 64'h4047;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL sn_grant: got %b expected 1", d_req_ready); end
        expQ.push_back('{1'b1, makeLine(64'hD000)});
        tick();
        d_req_valid = 0;
        bus_reqack  = 1;
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h4040, 13'h1101})
            begin errors++; $display("[TB] FAIL sn_addr: got cyc=%b req=%h tag=%h expected 1 4040 1101", bus_reqcyc, bus_req, bus_reqtag); end
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            bus_reqack  = 0;
            bus_respcyc = 1;
            bus_resptag = tags[c];
            bus_resp    = vals[c];
            @(negedge clk);
            if (bus_respack !== 1'b1) ok = 0;
            if (c == 4) begin
                checks++;
                if (inv_valid !== 1'b0) begin errors++; $display("[TB] FAIL sn_early: got inv_valid=%b expected 0", inv_valid); end
            end
            if (c == 5) begin
                checks++;
                if (inv_valid !== 1'b1 || inv_addr !== 64'h3000)
                    begin errors++; $display("[TB] FAIL sn_inv: got %b %h expected 1 3000", inv_valid, inv_addr); end
            end
            if (c == 6) begin
                checks++;
                if (inv_valid !== 1'b0) begin errors++; $display("[TB] FAIL sn_once: got inv_valid=%b expected 0", inv_valid); end
            end
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL sn_respack: got respack low on a response cycle, expected 1"); end
        tick();
        bus_respcyc = 0;
        bus_resp    = '0;
        bus_resptag = '0;
        wait_resp(got, side, data);
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL sn_resp: got no response");
        end else begin
            e = expQ.pop_front();
            checks++;
            if (side !== e.side || data !== e.data)
                begin errors++; $display("[TB] FAIL sn_line: got side=%b data=%h expected side=%b data=%h", side, data, e.side, e.data); end
        end
        tick();
        bus_respcyc = 1;
        bus_resptag = 13'h0800;
        bus_resp    = 64'h5000;
        @(negedge clk);
        tick();
        bus_resp = 64'h5040;
        @(negedge clk);
        checks++;
        if (inv_valid !== 1'b1 || inv_addr !== 64'h5000)
            begin errors++; $display("[TB] FAIL sn_back1: got %b %h expected 1 5000", inv_valid, inv_addr); end
        tick();
        bus_respcyc = 0;
        bus_resptag = '0;
        bus_resp    = '0;
        @(negedge clk);
        checks++;
        if (inv_valid !== 1'b1 || inv_addr !== 64'h5040)
            begin errors++; $display("[TB] FAIL sn_back2: got %b %h expected 1 5040", inv_valid, inv_addr); end
        tick();
        @(negedge clk);
        checks++;
        if (inv_valid !== 1'b0) begin errors++; $display("[TB] FAIL sn_end: got inv_valid=%b expected 0", inv_valid); end
    endtask

    task automatic test_reset_mid();
        int           i0, d0;
        bit           got, side, ok;
        logic [511:0] data;
        resp_t        e;
        tick();
        i_req_valid = 1;
        i_req_addr  = 64'h8000;
        @(negedge clk);
        tick();
        i_req_valid = 0;
        bus_reqack  = 1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            tick();
            bus_reqack  = 0;
            bus_respcyc = 1;
            bus_resptag = 13'h1100;
            bus_resp    = 64'hAA00 + 64'(k);
            @(negedge clk);
        end
        tick();
        reset    = 1;
        bus_resp = 64'hAA06;
        @(negedge clk);
        checks++;
        if (bus_respack !== 1'b0) begin errors++; $display("[TB] FAIL rm_ack: got respack=%b expected 0 in reset", bus_respack); end
        i0 = iCount;
        d0 = dCount;
        tick();
        reset       = 0;
        bus_respcyc = 0;
        bus_resp    = '0;
        bus_resptag = '0;
        @(negedge clk);
        checks++;
        if ({i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack} !== 7'b0)
            begin errors++; $display("[TB] FAIL rm_ctrl: got %b expected 0", {i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, inv_valid, bus_reqcyc, bus_respack}); end
        checks++;
        if ((|{i_resp_data, d_resp_data, inv_addr, bus_req, bus_reqtag}) !== 1'b0)
            begin errors++; $display("[TB] FAIL rm_data: some data output nonzero, expected all 0"); end
        repeat (5) tick();
        checks++;
        if (iCount !== i0 || dCount !== d0)
            begin errors++; $display("[TB] FAIL rm_noresp: got %0d/%0d pulses expected 0/0", iCount - i0, dCount - d0); end
        i_req_valid = 1;
        i_req_addr  = 64'h8000;
        @(negedge clk);
        checks++;
        if (i_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_grant: got %b expected 1", i_req_ready); end
        expQ.push_back('{1'b0, makeLine(64'hE000)});
        tick();
        i_req_valid = 0;
        @(negedge clk);
        bus_reqack = 1;
        serve_beats(1'b0, 64'hE000, ok);
        wait_resp(got, side, data);
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL rm_resp: got no response");
        end else begin
            e = expQ.pop_front();
            checks++;
            if (side !== e.side || data !== e.data)
                begin errors++; $display("[TB] FAIL rm_line: got side=%b data=%h expected side=%b data=%h", side, data, e.side, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_arbitration();
        test_write_back(64'h2000);
        test_write_back(64'h2018);
        test_snoop();
        test_reset_mid();
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard: got %0d leftover entries expected 0", expQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between the instruction-fetch line-fill path and the data-memory path (read line fills and 512-bit write-backs).
- Grants one requester at a time with round-robin fairness and drives the bus address/data beats.
- Assembles 8x64-bit response beats into a 512-bit line and returns it to the owner.
- Forwards bus invalidation snoops to the data side.

Parameters:
BUS_DATA_WIDTH, 64, bus data/address width
BUS_TAG_WIDTH, 13, bus tag width
LINE_BEATS, 8, beats per 512-bit cache line

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_req_valid  in  1  instruction side requests a line read
i_req_addr  in  64  instruction fetch address (any byte in line)
i_req_ready  out  1  one-cycle pulse: instruction request captured
i_resp_valid  out  1  one-cycle pulse: i_resp_data valid
i_resp_data  out  512  filled line, beat 0 in bits [63:0]
d_req_valid  in  1  data side requests a transaction
d_req_write  in  1  1 = write-back, 0 = line read
d_req_addr  in  64  data address
d_req_wdata  in  512  write-back line, beat 0 in bits [63:0]
d_req_ready  out  1  one-cycle pulse: data request captured
d_resp_valid  out  1  one-cycle pulse: read line valid, or write completed
d_resp_data  out  512  filled line (all zero after a write)
inv_valid  out  1  one-cycle pulse: snoop invalidate
inv_addr  out  64  physical address to invalidate
bus_reqcyc  out  1  Sysbus request cycle
bus_req  out  64  Sysbus request address/data
bus_reqtag  out  13  Sysbus request tag
bus_reqack  in  1  bus accepted address beat
bus_respcyc  in  1  Sysbus response cycle
bus_resp  in  64  Sysbus response data
bus_resptag  in  13  Sysbus response tag
bus_respack  out  1  response beat accepted

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0; line buffer 0; last_grant = DATA, so instruction wins the first tie. Reset mid-transaction aborts it: partial line discarded, no resp pulse.
- One outstanding transaction at a time.
- States: IDLE, ADDR, WR_DATA, RD_WAIT, DONE.
- IDLE:
  - Only one valid: grant it. Both valid: grant the requester that is not last_grant.
  - On grant: pulse the requester's req_ready for 1 cycle; latch addr, write flag and wdata; update last_grant; go to ADDR next cycle.
  - No grant while reset is high.
- ADDR:
  - Read: bus_reqcyc=1, bus_req = addr & ~63.
  - Write: bus_req = addr unmasked.
  - bus_reqtag = {rw, 4'b0001, 7'b0, id}, where rw: 1 = read, 0 = write; id: 0 = instruction, 1 = data.
  - Hold all three stable until a cycle with bus_reqack=1.
  - Next state: WR_DATA if write, else RD_WAIT.
- WR_DATA:
  - 8 consecutive cycles with bus_reqcyc=1, bus_req = wdata[64*k +: 64] for k=0..7, same tag.
  - No per-beat ack required.
  - Then DONE.
- RD_WAIT:
  - Each cycle with bus_respcyc=1 and bus_resptag == {1'b1, 4'b0001, 7'b0, id}: store bus_resp at beat k, k++.
  - After beat 7 go to DONE.
  - Read beats with a mismatched tag (other than snoop) are acked and dropped.
- DONE:
  - Drive the owner's resp_data from the buffer (zero for writes) and pulse resp_valid for 1 cycle; other requester's resp_valid stays 0.
  - Clear the counter; return to IDLE. Next grant occurs in the IDLE cycle, earliest 1 cycle after DONE.
- bus_respack = bus_respcyc, combinational, in every state except during reset.
- Snoop: any state, bus_respcyc=1 and bus_resptag == 13'b0_1000_0000_0000 → next cycle inv_valid=1, inv_addr=bus_resp for 1 cycle. Not counted as a read beat; does not disturb the transaction. Snoops on consecutive cycles give consecutive pulses.
- bus_reqcyc is 0 in IDLE, RD_WAIT and DONE.
- Minimum read latency: ADDR accept to resp_valid = 8 response beats + 1 cycle.

Test Plan:
- Instruction read, addr 0x1_0047, reqack after 2 cycles → bus_req=0x1_0040, tag=0x1100 held 3 cycles; beats 0x11..0x88 → i_resp_valid 1 cycle with data[63:0]=0x11, data[511:448]=0x88; d_resp_valid stays 0.
- i_req_valid and d_req_valid both high from reset, repeating → grant order instruction, data, instruction, data; each req_ready is a single pulse.
- Data write-back, addr 0x2000, wdata beat k = k+1 → ADDR beat 0x2000 with tag 0x0101, then 8 beats 1..8 on consecutive cycles; then d_resp_valid with d_resp_data=0.
- Snoop tag 0x0800 data 0x3000 injected between read beats 3 and 4 → inv_valid pulse with inv_addr=0x3000; line still assembles 8 beats correctly; respack high on all 9 cycles.
- reset asserted after read beat 5 → all outputs 0 next cycle, no resp_valid; a fresh request afterwards completes normally with a clean line.
